iprefetch_buf: RTL

- Next-line instruction prefetcher placed between the instruction cache's memory port and the slow instruction memory.
- Demand misses are forwarded to memory, returned to the cache, then line addr+1 is fetched into a one-line buffer.
- A later cache request to the buffered line completes in one cycle without touching memory.
- Writes pass through, and they invalidate a buffered line at the same address.

---
 rtl/iprefetch_buf_pkg.sv | 26 ++
 rtl/iprefetch_buf_if.sv | 16 +
 rtl/iprefetch_buf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/iprefetch_buf_pkg.sv
// Shared widths and FSM encoding for the next-line instruction prefetcher.
// The line/address widths are common to the cache-side and memory-side buses.
package iprefetch_buf_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HIT    = 3'd1;
    localparam logic [2:0] ST_DEMAND = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_WRESP  = 3'd5;
    localparam logic [2:0] ST_PREF   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        HIT    = ST_HIT,
        DEMAND = ST_DEMAND,
        RESP   = ST_RESP,
        WRITE  = ST_WRITE,
        WRESP  = ST_WRESP,
        PREF   = ST_PREF
    } state_t;

endpackage

// File: rtl/iprefetch_buf_if.sv
// Line-granular request/response bus used on both the cache side and the memory side.
// The requester owns read/write/addr/wdata; the responder owns rdata/ready.
interface iprefetch_buf_if #(
    parameter int LINE_W = iprefetch_buf_pkg::LINE_W,
    parameter int ADDR_W = iprefetch_buf_pkg::ADDR_W
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              ready;

    modport master (output read, write, addr, wdata, input rdata, ready);
    modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/iprefetch_buf.sv
// Next-line instruction prefetcher: forwards cache misses and writes to slow memory,
// then fetches line addr+1 into a one-line buffer so a sequential request hits in one cycle.
module iprefetch_buf #(
    parameter bit PF_EN  = 1'b1,
    parameter int LINE_W = iprefetch_buf_pkg::LINE_W,
    parameter int ADDR_W = iprefetch_buf_pkg::ADDR_W
) (
    input  logic            clk,
    input  logic            proc_reset,
    iprefetch_buf_if.slave  cache,
    iprefetch_buf_if.master mem,
    output logic [15:0]     pf_hits
);
    import iprefetch_buf_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic [ADDR_W-1:0] buf_tag;
    logic [LINE_W-1:0] buf_data;
    logic              buf_valid;
    logic [LINE_W-1:0] rdata_q;
    logic              ready_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              pf_ok;
    logic [ADDR_W-1:0] pf_addr;
    logic              buf_hit;

    // The top line never prefetches, so the buffer cannot wrap around to line 0.
    assign pf_addr = req_addr + ADDR_W'(1);
    assign pf_ok   = PF_EN && (req_addr != '1);
    assign buf_hit = buf_valid && (buf_tag == cache.addr);

    assign cache.rdata = rdata_q;
    assign cache.ready = ready_q;
    assign mem.read    = mem_read_q;
    assign mem.write   = mem_write_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wdata   = req_wdata;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_wdata   <= '0;
            buf_tag     <= '0;
            buf_data    <= '0;
            buf_valid   <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            pf_hits     <= 16'd0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cache.write) begin
                        req_addr    <= cache.addr;
                        req_wdata   <= cache.wdata;
                        mem_addr_q  <= cache.addr;
                        mem_write_q <= 1'b1;
                        if (buf_tag == cache.addr) buf_valid <= 1'b0;
                        state       <= WRITE;
                    end else if (cache.read && buf_hit) begin
                        req_addr <= cache.addr;
                        rdata_q  <= buf_data;
                        ready_q  <= 1'b1;
                        state    <= HIT;
                    end else if (cache.read) begin
                        req_addr   <= cache.addr;
                        mem_addr_q <= cache.addr;
                        mem_read_q <= 1'b1;
                        state      <= DEMAND;
                    end
                end
                DEMAND: begin
                    if (mem.ready) begin
                        rdata_q    <= mem.rdata;
                        mem_read_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= RESP;
                    end
                end
                // Both read completions fall through to the next-line fetch.
                HIT, RESP: begin
                    if (state == HIT && pf_hits != 16'hFFFF) pf_hits <= pf_hits + 16'd1;
                    if (pf_ok) begin
                        buf_valid  <= 1'b0;
                        buf_tag    <= pf_addr;
                        mem_addr_q <= pf_addr;
                        mem_read_q <= 1'b1;
                        state      <= PREF;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREF: begin
                    if (mem.ready) begin
                        buf_data   <= mem.rdata;
                        buf_valid  <= 1'b1;
                        mem_read_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem.ready) begin
                        mem_write_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= WRESP;
                    end
                end
                WRESP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
